// File: rtl/bk_prefix_sum16.sv
// Brent-Kung carry prefix stage: takes per-bit {p,g} pairs plus carry-in and
// produces sum/carry-out through a 3-stage pipeline with valid/ready backpressure.
module bk_prefix_sum16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] pg_in,
   input  logic               cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   sum,
   output logic               cout,
   output logic               pg_err
);

   localparam int unsigned LOG_W = $clog2(WIDTH);

   logic             adv;

   // S1: raw pairs
   logic             v1_q, v1_d;
   logic [WIDTH-1:0] p1_q, p1_d;
   logic [WIDTH-1:0] g1_q, g1_d;
   logic             cin1_q, cin1_d;
   logic             err1_q, err1_d;

   // S2: up-sweep group terms
   logic [WIDTH-1:0] gu, pu;
   logic             v2_q, v2_d;
   logic [WIDTH-1:0] p2_q, p2_d;
   logic [WIDTH-1:0] gu2_q, gu2_d;
   logic [WIDTH-1:0] pu2_q, pu2_d;
   logic             cin2_q, cin2_d;
   logic             err2_q, err2_d;

   // S3: final result
   logic [WIDTH-1:0] gd;
   logic [WIDTH:0]   carry;
   logic             v3_q, v3_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             err3_q, err3_d;

   // Whole pipeline moves together whenever the output slot is free or draining
   always_comb begin
      adv      = out_ready | ~v3_q;
      in_ready = adv;
   end

   // S1 next state: unpack pairs and flag any illegal {1,1} pair
   always_comb begin
      v1_d   = v1_q;
      p1_d   = p1_q;
      g1_d   = g1_q;
      cin1_d = cin1_q;
      err1_d = err1_q;
      if (adv) begin
         v1_d   = in_valid;
         cin1_d = cin;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            p1_d[i] = pg_in[2*i+1];
            g1_d[i] = pg_in[2*i];
         end
         err1_d = |(p1_d & g1_d);
      end
   end

   // Up-sweep: in-place group (G,P) at spans 2..WIDTH, cin folded into bit 0
   always_comb begin
      gu    = g1_q;
      pu    = p1_q;
      gu[0] = g1_q[0] | (p1_q[0] & cin1_q);
      for (int unsigned l = 1; l <= LOG_W; l++) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (((i + 1) % (32'd1 << l)) == 0) begin
               gu[i] = gu[i] | (pu[i] & gu[i - (32'd1 << (l - 1))]);
               pu[i] = pu[i] & pu[i - (32'd1 << (l - 1))];
            end
         end
      end
   end

   // S2 next state
   always_comb begin
      v2_d   = v2_q;
      p2_d   = p2_q;
      gu2_d  = gu2_q;
      pu2_d  = pu2_q;
      cin2_d = cin2_q;
      err2_d = err2_q;
      if (adv) begin
         v2_d   = v1_q;
         p2_d   = p1_q;
         gu2_d  = gu;
         pu2_d  = pu;
         cin2_d = cin1_q;
         err2_d = err1_q;
      end
   end

   // Down-sweep: fill the remaining prefixes from completed lower groups
   always_comb begin
      gd = gu2_q;
      for (int unsigned l = LOG_W - 1; l >= 1; l--) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((i >= (32'd1 << l)) && (((i + 1) % (32'd1 << l)) == (32'd1 << (l - 1)))) begin
               gd[i] = gd[i] | (pu2_q[i] & gd[i - (32'd1 << (l - 1))]);
            end
         end
      end
      carry = {gd, cin2_q};
   end

   // S3 next state: sum and carry-out
   always_comb begin
      v3_d   = v3_q;
      sum_d  = sum_q;
      cout_d = cout_q;
      err3_d = err3_q;
      if (adv) begin
         v3_d   = v2_q;
         sum_d  = p2_q ^ carry[WIDTH-1:0];
         cout_d = carry[WIDTH];
         err3_d = err2_q;
      end
   end

   // Valids and visible outputs, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         err3_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         v3_q   <= v3_d;
         sum_q  <= sum_d;
         cout_q <= cout_d;
         err3_q <= err3_d;
      end
   end

   // Internal data registers; meaning gated by their stage valid
   always_ff @(posedge clk) begin
      p1_q   <= p1_d;
      g1_q   <= g1_d;
      cin1_q <= cin1_d;
      err1_q <= err1_d;
      p2_q   <= p2_d;
      gu2_q  <= gu2_d;
      pu2_q  <= pu2_d;
      cin2_q <= cin2_d;
      err2_q <= err2_d;
   end

   always_comb begin
      out_valid = v3_q;
      sum       = sum_q;
      cout      = cout_q;
      pg_err    = err3_q;
   end

endmodule

// File: tb/tb_bk_prefix_sum16.sv
// Directed and random bench for bk_prefix_sum16.
module tb_bk_prefix_sum16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pg_in;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        pg_err;

   int checks   = 0;
   int failures = 0;

   bk_prefix_sum16 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pg_in     (pg_in),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .pg_err    (pg_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_pg(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] r;
      for (int i = 0; i < 16; i++) begin
         r[2*i+1] = a[i] ^ b[i];
         r[2*i]   = a[i] & b[i];
      end
      return r;
   endfunction

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pg_in = '0; cin = 1'b0;
      tick; tick; tick;
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
      checks++; if (cout !== 1'b0 || pg_err !== 1'b0) begin failures++; $display("FAIL reset_cout_err got=%b%b exp=00", cout, pg_err); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic;
      int lat;
      in_valid = 1'b1; pg_in = mk_pg(16'h00FF, 16'h0001); cin = 1'b0;
      lat = 0;
      do begin
         tick;
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      checks++; if (lat != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
      checks++; if (sum !== 16'h0100 || cout !== 1'b0 || pg_err !== 1'b0)
         begin failures++; $display("FAIL basic_result got=%h/%b/%b exp=0100/0/0", sum, cout, pg_err); end
      tick;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_carry_chain;
      logic [31:0] vpg[2];
      logic        vc[2];
      logic [15:0] es[2];
      logic        ec[2];
      int got, first;
      vpg[0] = mk_pg(16'hFFFF, 16'h0000); vc[0] = 1'b1; es[0] = 16'h0000; ec[0] = 1'b1;
      vpg[1] = mk_pg(16'hFFFF, 16'hFFFF); vc[1] = 1'b1; es[1] = 16'hFFFF; ec[1] = 1'b1;
      got = 0; first = -1;
      for (int t = 0; t < 10; t++) begin
         if (t < 2) begin in_valid = 1'b1; pg_in = vpg[t]; cin = vc[t]; end
         else in_valid = 1'b0;
         tick;
         if (out_valid) begin
            if (first < 0) first = t;
            checks++;
            if (got >= 2) begin failures++; $display("FAIL chain_extra got=%h exp=none", sum); end
            else if (t != first + got || sum !== es[got] || cout !== ec[got] || pg_err !== 1'b0) begin
               failures++; $display("FAIL chain_result idx=%0d got=%h/%b/%b exp=%h/%b/0", got, sum, cout, pg_err, es[got], ec[got]);
            end
            got++;
         end
      end
      checks++; if (first != 2 || got != 2) begin failures++; $display("FAIL chain_count got=%0d@%0d exp=2@2", got, first); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] va[4], vb[4], es[4];
      logic        ec[4];
      int got, first;
      va[0] = 16'h1234; vb[0] = 16'h1111; es[0] = 16'h2345; ec[0] = 1'b0;
      va[1] = 16'h8000; vb[1] = 16'h8000; es[1] = 16'h0000; ec[1] = 1'b1;
      va[2] = 16'h7FFF; vb[2] = 16'h0001; es[2] = 16'h8000; ec[2] = 1'b0;
      va[3] = 16'h0000; vb[3] = 16'h0000; es[3] = 16'h0000; ec[3] = 1'b0;
      got = 0; first = -1;
      for (int t = 0; t < 12; t++) begin
         if (t < 4) begin in_valid = 1'b1; pg_in = mk_pg(va[t], vb[t]); cin = 1'b0; end
         else in_valid = 1'b0;
         tick;
         if (out_valid) begin
            if (first < 0) first = t;
            checks++;
            if (got >= 4) begin failures++; $display("FAIL b2b_extra got=%h exp=none", sum); end
            else if (t != first + got || sum !== es[got] || cout !== ec[got] || pg_err !== 1'b0) begin
               failures++; $display("FAIL b2b_result idx=%0d got=%h/%b/%b exp=%h/%b/0", got, sum, cout, pg_err, es[got], ec[got]);
            end
            got++;
         end
      end
      checks++; if (first != 2 || got != 4) begin failures++; $display("FAIL b2b_count got=%0d@%0d exp=4@2", got, first); end
   endtask

   task automatic test_stall;
      logic [15:0] va[3], vb[3], es[3];
      logic        ec[3];
      va[0] = 16'h0001; vb[0] = 16'h0002; es[0] = 16'h0003; ec[0] = 1'b0;
      va[1] = 16'hAAAA; vb[1] = 16'h5555; es[1] = 16'hFFFF; ec[1] = 1'b0;
      va[2] = 16'hFFFF; vb[2] = 16'h0001; es[2] = 16'h0000; ec[2] = 1'b1;
      out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         in_valid = 1'b1; pg_in = mk_pg(va[t], vb[t]); cin = 1'b0;
         tick;
      end
      in_valid = 1'b0;
      for (int t = 0; t < 5; t++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es[0] || cout !== ec[0]) begin
            failures++; $display("FAIL stall_hold cyc=%0d got=v%b r%b %h/%b exp=v1 r0 %h/%b", t, out_valid, in_ready, sum, cout, es[0], ec[0]);
         end
         tick;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1'b1 || sum !== es[k] || cout !== ec[k] || pg_err !== 1'b0) begin
            failures++; $display("FAIL stall_release idx=%0d got=v%b %h/%b/%b exp=v1 %h/%b/0", k, out_valid, sum, cout, pg_err, es[k], ec[k]);
         end
         tick;
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_pg_err;
      logic [31:0] vpg[2];
      logic [15:0] es[2];
      logic        ee[2];
      int got, first;
      vpg[0] = 32'h0000_0C00;                  es[0] = 16'h0060; ee[0] = 1'b1;
      vpg[1] = mk_pg(16'h0003, 16'h0005);      es[1] = 16'h0008; ee[1] = 1'b0;
      got = 0; first = -1;
      for (int t = 0; t < 10; t++) begin
         if (t < 2) begin in_valid = 1'b1; pg_in = vpg[t]; cin = 1'b0; end
         else in_valid = 1'b0;
         tick;
         if (out_valid) begin
            if (first < 0) first = t;
            checks++;
            if (got >= 2) begin failures++; $display("FAIL err_extra got=%h exp=none", sum); end
            else if (t != first + got || sum !== es[got] || cout !== 1'b0 || pg_err !== ee[got]) begin
               failures++; $display("FAIL err_result idx=%0d got=%h/%b/%b exp=%h/0/%b", got, sum, cout, pg_err, es[got], ee[got]);
            end
            got++;
         end
      end
      checks++; if (got != 2) begin failures++; $display("FAIL err_count got=%0d exp=2", got); end
   endtask

   task automatic test_reset_mid;
      int lat;
      out_ready = 1'b1;
      in_valid = 1'b1; pg_in = mk_pg(16'h1111, 16'h2222); cin = 1'b0; tick;
      pg_in = mk_pg(16'h4444, 16'h1111); tick;
      in_valid = 1'b0; rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_flush got=v%b r%b exp=v0 r1", out_valid, in_ready); end
      for (int t = 0; t < 4; t++) begin
         tick;
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ghost cyc=%0d got=%b exp=0", t, out_valid); end
      end
      in_valid = 1'b1; pg_in = mk_pg(16'h0010, 16'h0020); cin = 1'b0;
      lat = 0;
      do begin
         tick;
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      checks++; if (lat != 3 || sum !== 16'h0030 || cout !== 1'b0)
         begin failures++; $display("FAIL rstmid_post got=%h/%b lat=%0d exp=0030/0 lat=3", sum, cout, lat); end
      tick;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_single got=%b exp=0", out_valid); end
   endtask

   task automatic test_random;
      localparam int N = 10000;
      logic [16:0] q[$];
      logic [16:0] exp_v;
      logic [17:0] held;
      logic        held_v;
      logic [15:0] a, b;
      logic        c;
      int sent, got, cyc;
      sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
      while ((sent < N || q.size() != 0) && cyc < 60000) begin
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
         in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
         pg_in     = mk_pg(a, b);
         cin       = c;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (held_v) begin
            checks++;
            if (out_valid !== 1'b1 || {pg_err, cout, sum} !== held) begin
               failures++;
               if (failures < 30) $display("FAIL rand_hold got=v%b %h exp=v1 %h", out_valid, {pg_err, cout, sum}, held);
            end
         end
         if (in_valid && in_ready) begin
            q.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               if (failures < 30) $display("FAIL rand_spurious got=%h exp=none", {cout, sum});
            end else begin
               exp_v = q.pop_front();
               if ({cout, sum} !== exp_v || pg_err !== 1'b0) begin
                  failures++;
                  if (failures < 30) $display("FAIL rand_result idx=%0d got=%h/%b exp=%h/0", got, {cout, sum}, pg_err, exp_v);
               end
            end
            got++;
         end
         held_v = out_valid && !out_ready;
         held   = {pg_err, cout, sum};
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != N || sent != N) begin failures++; $display("FAIL rand_count got=%0d sent=%0d exp=%0d", got, sent, N); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pg_in = '0; cin = 1'b0;
      test_reset;
      test_basic;
      test_carry_chain;
      test_back_to_back;
      test_stall;
      test_pg_err;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
